best_weight_keeper: RTL and testbench
=====================================

BEST_WEIGHT_KEEPER -- requirements
Module: best_weight_keeper

Interface
REQ-001 Parameter BIT_WIDTH, default 32, mantissa width of one weight.
REQ-002 Parameter EXTRA_BIT, default 2, guard bits; weight word width W = BIT_WIDTH+EXTRA_BIT.
REQ-003 Parameter NUM_WEIGHTS, default 8, weights per epoch (channel count), >=2.
REQ-004 Parameter ERR_WIDTH, default 32, unsigned epoch-error width.
REQ-005 Parameter PATIENCE, default 4, non-improving epochs before early stop (used only with REQ-031).
REQ-006 Clocking: one clock; reset is synchronous and active-high.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 w_valid  in  1  weight beat valid.
REQ-010 w_data  in  W  weight beat value.
REQ-011 w_last  in  1  marks final beat of an epoch.
REQ-012 err_valid  in  1  epoch error valid.
REQ-013 err_data  in  ERR_WIDTH  epoch error, unsigned.
REQ-014 training_finish  in  1  selects best bank for readout; blocks new epochs.
REQ-015 rd_addr  in  clog2(NUM_WEIGHTS)  readout index.
REQ-016 rd_data  out  W  registered readout weight.
REQ-017 busy  out  1  high in WAIT_ERR and COMMIT.
REQ-018 best_valid  out  1  at least one epoch committed.
REQ-019 best_err  out  ERR_WIDTH  lowest committed error.
REQ-020 epoch_cnt  out  16  completed epochs, saturating.
REQ-021 protocol_err  out  1  sticky framing error.
REQ-022 early_stop  out  1  patience exhausted.

Function
REQ-023 FSM states IDLE, COLLECT, WAIT_ERR, COMMIT; storage: shadow bank and best bank, NUM_WEIGHTS x W each.
REQ-024 IDLE: w_valid and not training_finish -> write shadow[0], ptr=1, go COLLECT; otherwise w_valid ignored.
REQ-025 COLLECT: each w_valid writes shadow[ptr], ptr+1; w_last on beat NUM_WEIGHTS-1 -> WAIT_ERR; w_last on any other beat, or beat NUM_WEIGHTS without w_last -> protocol_err=1, epoch discarded, go IDLE.
REQ-026 WAIT_ERR: w_valid ignored; on err_valid epoch_cnt+1 (saturate at 16'hFFFF); if not best_valid or err_data < best_err go COMMIT, else go IDLE; err_valid in other states ignored.
REQ-027 COMMIT: single cycle; all shadow entries copied to best bank, best_err=err_data latched in WAIT_ERR, best_valid=1; go IDLE.
REQ-028 Equal error does not commit; earliest best epoch retained.
REQ-029 rd_data latency 1 cycle: best[rd_addr] when training_finish and best_valid, else shadow[rd_addr]; rd_addr >= NUM_WEIGHTS -> 0.
REQ-030 training_finish asserted mid-epoch: current epoch completes normally (including commit); only new epochs blocked.

Configuration
REQ-031 Macro BEST_WEIGHT_PATIENCE_EN defined: stall counter increments on each non-committing err_valid, clears on COMMIT; when it reaches PATIENCE, early_stop=1, sticky until rst.
REQ-032 Macro undefined: no stall counter; early_stop tied 0.

Reset
REQ-033 rst: state IDLE, ptr 0, both banks 0, rd_data 0, best_err 0, best_valid 0, epoch_cnt 0, protocol_err 0, early_stop 0, stall counter 0; rst mid-epoch discards partial epoch.

Verification
REQ-034 NUM_WEIGHTS=8, beats 1..8 with w_last on 8th, err 100 -> COMMIT one cycle, best_err=100, epoch_cnt=1, training_finish=1, rd_addr=3 -> rd_data=4 next cycle.
REQ-035 Second epoch beats 11..18, err 150 -> no commit; readout under training_finish still returns 1..8; err 100 again -> no commit (tie).
REQ-036 w_last on beat 5 -> protocol_err=1, state IDLE, best bank unchanged, epoch_cnt unchanged.
REQ-037 With BEST_WEIGHT_PATIENCE_EN, PATIENCE=4: commit err 50 then four epochs err 60 -> early_stop=1 after 4th err_valid; without macro early_stop stays 0.
REQ-038 rst asserted on beat 4 of an epoch -> all outputs 0 next cycle; following full epoch err 999 commits as first best.

Source files
------------

// File: rtl/best_weight_keeper.sv
// best_weight_keeper
//   Collects one epoch of NUM_WEIGHTS weight beats into a shadow bank, waits
//   for that epoch's error, and copies the shadow bank into the best bank
//   whenever the error is strictly lower than the best seen so far.
//
// Ports
//   clk, rst                    rising-edge clock, synchronous active-high reset
//   w_valid, w_data, w_last     weight beat stream (w_last on the final beat)
//   err_valid, err_data         per-epoch error (unsigned)
//   training_finish             readout from the best bank, blocks new epochs
//   rd_addr -> rd_data          registered readout, 1-cycle latency
//   busy                        high while waiting for an error or committing
//   best_valid, best_err        a best epoch exists / its error
//   epoch_cnt                   completed epochs, saturating at 16'hFFFF
//   protocol_err                sticky framing error
//   early_stop                  patience exhausted (sticky)
//
// Optional feature: define BEST_WEIGHT_PATIENCE_EN to enable the stall
// counter and early_stop. Without it early_stop is tied low.
module best_weight_keeper #(
  parameter int BIT_WIDTH   = 32,
  parameter int EXTRA_BIT   = 2,
  parameter int NUM_WEIGHTS = 8,
  parameter int ERR_WIDTH   = 32,
  parameter int PATIENCE    = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           w_valid,
  input  logic [BIT_WIDTH+EXTRA_BIT-1:0] w_data,
  input  logic                           w_last,
  input  logic                           err_valid,
  input  logic [ERR_WIDTH-1:0]           err_data,
  input  logic                           training_finish,
  input  logic [$clog2(NUM_WEIGHTS)-1:0] rd_addr,
  output logic [BIT_WIDTH+EXTRA_BIT-1:0] rd_data,
  output logic                           busy,
  output logic                           best_valid,
  output logic [ERR_WIDTH-1:0]           best_err,
  output logic [15:0]                    epoch_cnt,
  output logic                           protocol_err,
  output logic                           early_stop
);
  localparam int W  = BIT_WIDTH + EXTRA_BIT;
  localparam int AW = $clog2(NUM_WEIGHTS);
  // ptr must be able to reach NUM_WEIGHTS to detect an overlong epoch
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] NW_P     = PW'(NUM_WEIGHTS);
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_WEIGHTS - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, WAIT_ERR, COMMIT} state_t;

  state_t               state;
  logic [PW-1:0]        ptr;
  logic [W-1:0]         shadow [NUM_WEIGHTS];
  logic [W-1:0]         best   [NUM_WEIGHTS];
  logic [ERR_WIDTH-1:0] pend_err;

  wire improve = !best_valid || (err_data < best_err);

  assign busy = (state == WAIT_ERR) || (state == COMMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= '0;
      pend_err     <= '0;
      best_valid   <= 1'b0;
      best_err     <= '0;
      epoch_cnt    <= '0;
      protocol_err <= 1'b0;
      for (int i = 0; i < NUM_WEIGHTS; i++) begin
        shadow[i] <= '0;
        best[i]   <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (w_valid && !training_finish) begin
            shadow[0] <= w_data;
            // NUM_WEIGHTS >= 2, so a last flag on the first beat is a framing error
            if (w_last) begin
              protocol_err <= 1'b1;
              ptr          <= '0;
            end else begin
              ptr   <= PW'(1);
              state <= COLLECT;
            end
          end
        end
        COLLECT: begin
          if (w_valid) begin
            if (ptr < NW_P) shadow[ptr[AW-1:0]] <= w_data;
            if (w_last && ptr == LAST_IDX) begin
              state <= WAIT_ERR;
            end else if (w_last || ptr == NW_P) begin
              protocol_err <= 1'b1;
              ptr          <= '0;
              state        <= IDLE;
            end else begin
              ptr <= ptr + PW'(1);
            end
          end
        end
        WAIT_ERR: begin
          if (err_valid) begin
            pend_err <= err_data;
            ptr      <= '0;
            if (epoch_cnt != 16'hFFFF) epoch_cnt <= epoch_cnt + 16'd1;
            // strict compare: a tie keeps the earlier best epoch
            state <= improve ? COMMIT : IDLE;
          end
        end
        COMMIT: begin
          for (int i = 0; i < NUM_WEIGHTS; i++) best[i] <= shadow[i];
          best_err   <= pend_err;
          best_valid <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Readout: best bank only once training is finished and a best exists
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (PW'(rd_addr) >= NW_P) begin
      rd_data <= '0;
    end else if (training_finish && best_valid) begin
      rd_data <= best[rd_addr];
    end else begin
      rd_data <= shadow[rd_addr];
    end
  end

`ifdef BEST_WEIGHT_PATIENCE_EN
  localparam int SW = $clog2(PATIENCE + 1) + 1;
  localparam logic [SW-1:0] PAT = SW'(PATIENCE);

  logic [SW-1:0] stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall      <= '0;
      early_stop <= 1'b0;
    end else if (state == COMMIT) begin
      stall <= '0;
    end else if (state == WAIT_ERR && err_valid && !improve) begin
      if (stall < PAT) stall <= stall + SW'(1);
      // stall is about to reach PATIENCE with this non-improving epoch
      if (stall + SW'(1) >= PAT) early_stop <= 1'b1;
    end
  end
`else
  assign early_stop = 1'b0;
`endif

endmodule

// File: tb/tb_best_weight_keeper.sv
// Directed bench for best_weight_keeper (default parameters, NUM_WEIGHTS=8).
// Readout expectations go through a scoreboard queue: pushed when rd_addr is
// driven, popped when rd_data is valid one cycle later.
module tb_best_weight_keeper;
  localparam int W  = 34;
  localparam int EW = 32;
`ifdef BEST_WEIGHT_PATIENCE_EN
  localparam logic ES_EXP = 1'b1;
`else
  localparam logic ES_EXP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          w_valid, w_last, err_valid, training_finish;
  logic [W-1:0]  w_data;
  logic [EW-1:0] err_data;
  logic [2:0]    rd_addr;
  logic [W-1:0]  rd_data;
  logic          busy, best_valid, protocol_err, early_stop;
  logic [EW-1:0] best_err;
  logic [15:0]   epoch_cnt;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  best_weight_keeper dut (
    .clk(clk), .rst(rst), .w_valid(w_valid), .w_data(w_data), .w_last(w_last),
    .err_valid(err_valid), .err_data(err_data), .training_finish(training_finish),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .best_valid(best_valid),
    .best_err(best_err), .epoch_cnt(epoch_cnt), .protocol_err(protocol_err),
    .early_stop(early_stop)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Beats base+1 .. base+n, w_last on beat index last_at (0 = none)
  task automatic epoch(input int base, input int n, input int last_at);
    for (int i = 1; i <= n; i++) begin
      w_valid = 1'b1;
      w_data  = W'(base + i);
      w_last  = (i == last_at);
      tick();
    end
    w_valid = 1'b0;
    w_last  = 1'b0;
  endtask

  task automatic send_err(input int e);
    err_valid = 1'b1;
    err_data  = EW'(e);
    tick();
    err_valid = 1'b0;
  endtask

  // Full epoch + error; lands back in IDLE after any commit
  task automatic full_epoch(input int base, input int e, input bit commit);
    epoch(base, 8, 8);
    send_err(e);
    if (commit) tick();
  endtask

  task automatic rd(input string tag, input int addr, input int expv);
    rd_addr = 3'(addr);
    exp_q.push_back(W'(expv));
    tick();
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      chk(tag, 64'(rd_data), 64'(exp_q.pop_front()));
    end
  endtask

  initial begin
    rst = 1'b1; w_valid = 1'b0; w_last = 1'b0; w_data = '0;
    err_valid = 1'b0; err_data = '0; training_finish = 1'b0; rd_addr = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_rd_data", 64'(rd_data), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_best_valid", 64'(best_valid), 0);
    chk("rst_best_err", 64'(best_err), 0);
    chk("rst_epoch_cnt", 64'(epoch_cnt), 0);
    chk("rst_protocol_err", 64'(protocol_err), 0);
    chk("rst_early_stop", 64'(early_stop), 0);

    // Epoch 1: beats 1..8, err 100 commits
    epoch(0, 8, 8);
    chk("e1_wait_busy", 64'(busy), 1);
    send_err(100);
    chk("e1_commit_busy", 64'(busy), 1);
    chk("e1_commit_cnt", 64'(epoch_cnt), 1);
    chk("e1_commit_bv_pending", 64'(best_valid), 0);
    tick();
    chk("e1_idle_busy", 64'(busy), 0);
    chk("e1_best_valid", 64'(best_valid), 1);
    chk("e1_best_err", 64'(best_err), 100);
    training_finish = 1'b1;
    rd("e1_rd3", 3, 4);
    rd("e1_rd7", 7, 8);

    // New epoch blocked while training_finish is high
    epoch(50, 1, 0);
    chk("tf_block_busy", 64'(busy), 0);
    training_finish = 1'b0;
    rd("tf_block_shadow0", 0, 1);

    // Epoch 2: err 150, no commit
    full_epoch(10, 150, 0);
    chk("e2_busy", 64'(busy), 0);
    chk("e2_cnt", 64'(epoch_cnt), 2);
    chk("e2_best_err", 64'(best_err), 100);
    rd("e2_shadow3", 3, 14);
    training_finish = 1'b1;
    rd("e2_best3", 3, 4);
    training_finish = 1'b0;

    // Epoch 3: equal err 100, no commit
    full_epoch(20, 100, 0);
    chk("e3_cnt", 64'(epoch_cnt), 3);
    training_finish = 1'b1;
    rd("e3_tie_best0", 0, 1);
    training_finish = 1'b0;

    // Short epoch: w_last on beat 5
    epoch(30, 5, 5);
    chk("pe_protocol_err", 64'(protocol_err), 1);
    chk("pe_busy", 64'(busy), 0);
    chk("pe_cnt", 64'(epoch_cnt), 3);
    chk("pe_best_err", 64'(best_err), 100);
    training_finish = 1'b1;
    rd("pe_best5", 5, 6);
    training_finish = 1'b0;

    // Reset on beat 4 of an epoch
    epoch(40, 3, 0);
    w_valid = 1'b1; w_data = W'(44); rst = 1'b1;
    tick();
    w_valid = 1'b0; rst = 1'b0;
    chk("mr_rd_data", 64'(rd_data), 0);
    chk("mr_busy", 64'(busy), 0);
    chk("mr_best_valid", 64'(best_valid), 0);
    chk("mr_best_err", 64'(best_err), 0);
    chk("mr_cnt", 64'(epoch_cnt), 0);
    chk("mr_protocol_err", 64'(protocol_err), 0);
    chk("mr_early_stop", 64'(early_stop), 0);
    full_epoch(990, 999, 1);
    chk("mr_first_best_err", 64'(best_err), 999);
    chk("mr_first_cnt", 64'(epoch_cnt), 1);
    training_finish = 1'b1;
    rd("mr_best7", 7, 998);
    training_finish = 1'b0;

    // Patience: commit 50, then four epochs at 60
    full_epoch(100, 50, 1);
    chk("pat_best_err", 64'(best_err), 50);
    for (int k = 0; k < 3; k++) full_epoch(110 + 10 * k, 60, 0);
    chk("pat_es_after3", 64'(early_stop), 0);
    full_epoch(140, 60, 0);
    chk("pat_es_after4", 64'(early_stop), 64'(ES_EXP));
    chk("pat_cnt", 64'(epoch_cnt), 6);

    // training_finish raised mid-epoch: epoch still completes and commits
    epoch(200, 4, 0);
    training_finish = 1'b1;
    epoch(204, 4, 4);
    chk("mid_tf_busy", 64'(busy), 1);
    send_err(40);
    tick();
    chk("mid_tf_best_err", 64'(best_err), 40);
    chk("mid_tf_cnt", 64'(epoch_cnt), 7);
    chk("mid_tf_es_sticky", 64'(early_stop), 64'(ES_EXP));
    rd("mid_tf_best5", 5, 206);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
